// File: rtl/wishbone_classic_arbiter.sv
// N-to-1 Wishbone B4 classic arbiter with round-robin grant and combinational request/response routing.
// Optional response watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_classic_arbiter #(
    parameter int unsigned NUM_CTRL  = 4,
    parameter int unsigned ADR_WIDTH = 32,
    parameter int unsigned DAT_WIDTH = 8,
    parameter int unsigned TIMEOUT   = 255,
    localparam int unsigned SEL_WIDTH = DAT_WIDTH / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_CTRL-1:0]           c_cyc_i,
    input  logic [NUM_CTRL-1:0]           c_stb_i,
    input  logic [NUM_CTRL-1:0]           c_we_i,
    input  logic [NUM_CTRL*ADR_WIDTH-1:0] c_adr_i,
    input  logic [NUM_CTRL*SEL_WIDTH-1:0] c_sel_i,
    input  logic [NUM_CTRL*DAT_WIDTH-1:0] c_dat_i,
    output logic [NUM_CTRL-1:0]           c_ack_o,
    output logic [NUM_CTRL-1:0]           c_err_o,
    output logic [NUM_CTRL-1:0]           c_rty_o,
    output logic [DAT_WIDTH-1:0]          c_dat_o,
    output logic                          d_cyc_o,
    output logic                          d_stb_o,
    output logic                          d_we_o,
    output logic [ADR_WIDTH-1:0]          d_adr_o,
    output logic [SEL_WIDTH-1:0]          d_sel_o,
    output logic [DAT_WIDTH-1:0]          d_dat_o,
    input  logic                          d_ack_i,
    input  logic                          d_err_i,
    input  logic                          d_rty_i,
    input  logic [DAT_WIDTH-1:0]          d_dat_i,
    output logic [NUM_CTRL-1:0]           grant_o
);

    localparam int unsigned IDX_W = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t               state_q;
    logic [NUM_CTRL-1:0]  grant_q;
    logic [IDX_W-1:0]     last_q;

    logic                 active;
    logic                 timeout_c;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    int unsigned          cand;

    logic                 g_cyc;
    logic                 g_stb;
    logic                 g_we;
    logic [ADR_WIDTH-1:0] g_adr;
    logic [SEL_WIDTH-1:0] g_sel;
    logic [DAT_WIDTH-1:0] g_dat;

    assign active  = (state_q == GRANTED);
    assign grant_o = grant_q;

    // Round-robin pick: first requester after the last owner, wrapping modulo NUM_CTRL.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last_q;
        cand       = 0;
        for (int unsigned i = 1; i <= NUM_CTRL; i++) begin
            cand = 32'(last_q) + i;
            if (cand >= NUM_CTRL) begin
                cand = cand - NUM_CTRL;
            end
            if (!pick_valid && c_cyc_i[IDX_W'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Request fields of the current owner (last_q holds the owner while granted).
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_sel = '0;
        g_dat = '0;
        for (int unsigned k = 0; k < NUM_CTRL; k++) begin
            if (last_q == IDX_W'(k)) begin
                g_cyc = c_cyc_i[k];
                g_stb = c_stb_i[k];
                g_we  = c_we_i[k];
                g_adr = c_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
                g_sel = c_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
                g_dat = c_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    assign timeout_c = active && (cnt_q == CNT_W'(TIMEOUT));

    // Watchdog counts consecutive strobed cycles without any device response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!active || timeout_c || !g_cyc || !g_stb || d_ack_i || d_err_i || d_rty_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT);
    assign timeout_c      = 1'b0;
`endif

    // Device side mirrors the owner; everything is quiet when idle or in reset.
    assign d_cyc_o = active & g_cyc & ~timeout_c;
    assign d_stb_o = active & g_stb & ~timeout_c;
    assign d_we_o  = active & g_we;
    assign d_adr_o = active ? g_adr : '0;
    assign d_sel_o = active ? g_sel : '0;
    assign d_dat_o = active ? g_dat : '0;

    assign c_ack_o = grant_q & {NUM_CTRL{d_ack_i}};
    assign c_err_o = grant_q & {NUM_CTRL{d_err_i | timeout_c}};
    assign c_rty_o = grant_q & {NUM_CTRL{d_rty_i}};
    assign c_dat_o = rst_ni ? d_dat_i : '0;

    // Grant FSM: a release always passes through IDLE, leaving one idle bus cycle between owners.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_CTRL - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= GRANTED;
                        grant_q <= NUM_CTRL'(1) << pick_idx;
                        last_q  <= pick_idx;
                    end
                end
                GRANTED: begin
                    if (!g_cyc || timeout_c) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule
